serial_char_tx: RTL and testbench
=================================

# serial_char_tx

Serial character transmitter for the SerialComm link. It is the sending end of the same asynchronous frame that the receiver's start-bit detector watches for. The block takes one parallel character per handshake and serializes it onto an idle-high line: a low start bit, DATA_BITS data bits LSB first, then STOP_BITS high stop bits. It sits between the character source (keyboard/ROM/FSM) and the board pin that drives the receiver's `data` input. It reports frame completion with a one-cycle `char_complete` pulse.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit time; legal range 2–1024.
- `DATA_BITS`, default 8: data bits per character; legal range 5–8.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.

- `clk`  input  1: single clock; all logic is rising-edge.
- `reset_n`  input  1: synchronous, active-low reset.
- `tx_data`  input  DATA_BITS: character to send; sampled only on an accepted handshake.
- `tx_valid`  input  1: source has a character.
- `tx_ready`  output  1: block can accept a character; combinational, equal to (state == IDLE).
- `tx_out`  output  1: serial line, registered; idle level is 1.
- `busy`  output  1: a frame is in progress (state != IDLE).
- `char_complete`  output  1: one-cycle pulse when the final stop bit ends.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx_out`=1.
  - If `tx_valid & tx_ready`: latch `tx_data` into the shift register, clear the bit-time counter, go to START.
- START:
  - `tx_out`=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
- DATA:
  - `tx_out`=shift[0] for CLKS_PER_BIT cycles.
  - Then shift right by one and increment the index.
  - After bit DATA_BITS-1 completes, go to STOP.
- STOP:
  - `tx_out`=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
- `char_complete`:
  - Registered; high exactly during the first IDLE cycle after STOP.
  - This coincides with `tx_ready` rising.
- Holding register: changes to `tx_data` after acceptance have no effect on the frame in flight.
- `tx_valid` while busy is ignored; no queueing. The source must hold `tx_valid` until it sees `tx_ready`.
- Counter widths:
  - Bit-time counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1.
  - Bit index is $clog2(DATA_BITS+1) bits.
  - No other arithmetic.

## Timing
- Reset values, one cycle after `reset_n` is sampled low:
  - state=IDLE, `tx_out`=1, `busy`=0, `char_complete`=0, `tx_ready`=1.
  - Counters and shift register are cleared to 0.
- Reset mid-frame aborts the frame. The line returns high on the next edge, and no `char_complete` is produced.
- Acceptance:
  - Handshake on edge N.
  - `tx_out` falls to 0 on edge N+1; `busy`=1 and `tx_ready`=0 from that edge.
- Frame length, from the first start-bit cycle to the last stop-bit cycle: (1+DATA_BITS+STOP_BITS)×CLKS_PER_BIT cycles. Default: 160 cycles.
- Back-to-back:
  - A handshake in the `char_complete` cycle is legal.
  - The next start bit begins one cycle later, so the minimum inter-frame idle is exactly 1 clock of extra stop level.
- Simultaneous `reset_n` low and handshake: reset wins; the character is dropped.
- Changes on `tx_out` occur only on bit boundaries; it is glitch-free (flop output).

## Structure
- Package `serial_pkg`, shared with the receiver side:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t`
  - Constants `START_LEVEL`=1'b0, `STOP_LEVEL`=1'b1, `IDLE_LEVEL`=1'b1.
- Sub-module `bit_timer`:
  - Parameterized by CLKS_PER_BIT.
  - Inputs `clk`, `reset_n`, `clear`; output `bit_tick`, a one-cycle pulse on the last cycle of each bit time.
  - The receiver reuses it.
- Top level: FSM, shift register, index counter and output flops.

## Test plan
- **Reset:**
  - Hold `reset_n`=0 for 3 cycles with `tx_valid`=1 → `tx_out`=1, `tx_ready`=1, `busy`=0, `char_complete`=0 throughout.
  - No frame may start until after release.
- **Single frame** (CLKS_PER_BIT=4, 8'hA5):
  - Line runs 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
  - `char_complete` pulses once on cycle 41 after acceptance.
- **Back-to-back** (8'h00 then 8'hFF):
  - Hold `tx_valid` continuously.
  - Second start bit begins exactly 1 cycle after the `char_complete` cycle.
  - Exactly 2 `char_complete` pulses.
- **Busy-ignore:**
  - Pulse `tx_valid` with 8'h3C mid-frame of 8'h81.
  - The 8'h81 frame is unchanged, 8'h3C is never transmitted, and `tx_data` changes mid-frame do not alter the line.
- **Reset mid-frame:**
  - Assert `reset_n`=0 for 1 cycle during DATA bit 3.
  - `tx_out`=1 on the next edge, no `char_complete`, and a new frame is accepted afterwards.
- **Loopback:**
  - Drive `tx_out` into the receiver's `data` input; use 2 stop bits and 7 data bits.
  - The receiver's enable rises on the start-bit falling edge.
  - Received character matches for 8'h55 and 8'h2A.

Source files
------------

// File: rtl/serial_pkg.sv
// ============================================================================
// serial_pkg : shared types and line levels for the SerialComm link
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_char_tx_bit_timer.sv
// ============================================================================
// bit_timer : free-running bit-time counter, pulses on the last cycle of a bit
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bit_tick = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || bit_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_char_tx.sv
// ============================================================================
// serial_char_tx : parallel-to-serial character transmitter (start/data/stop)
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_char_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 char_complete
);

    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] C_LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] C_LAST_STOP = IW'(STOP_BITS - 1);

    tx_state_t              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   tx_out_q, tx_out_d;
    logic                   cc_q, cc_d;
    logic                   w_bit_tick;
    logic                   w_timer_clear;

    // Timer is held at zero while idle so the start bit gets a full bit time.
    assign w_timer_clear = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (w_timer_clear),
        .bit_tick (w_bit_tick)
    );

    assign tx_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign tx_out        = tx_out_q;
    assign char_complete = cc_q;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        tx_out_d = tx_out_q;
        cc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_out_d = IDLE_LEVEL;
                if (tx_valid && tx_ready) begin
                    shift_d  = tx_data;
                    state_d  = START;
                    tx_out_d = START_LEVEL;
                end
            end
            START: begin
                if (w_bit_tick) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    tx_out_d = shift_q[0];
                end
            end
            DATA: begin
                if (w_bit_tick) begin
                    if (idx_q == C_LAST_BIT) begin
                        state_d  = STOP;
                        idx_d    = '0;
                        tx_out_d = STOP_LEVEL;
                    end else begin
                        shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
                        idx_d    = idx_q + IW'(1);
                        tx_out_d = shift_d[0];
                    end
                end
            end
            STOP: begin
                // The index counter doubles as the stop-bit counter.
                if (w_bit_tick) begin
                    if (idx_q == C_LAST_STOP) begin
                        state_d  = IDLE;
                        idx_d    = '0;
                        cc_d     = 1'b1;
                        tx_out_d = IDLE_LEVEL;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                tx_out_d = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            tx_out_q <= IDLE_LEVEL;
            cc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            tx_out_q <= tx_out_d;
            cc_q     <= cc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_char_tx.sv
// ============================================================================
// tb_serial_char_tx : directed self-checking bench for serial_char_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_char_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'hA5;
    logic       tx_valid = 1'b1;
    logic       tx_ready, tx_out, busy, cc;

    logic [6:0] lb_data = 7'h00;
    logic       lb_valid = 1'b0;
    logic       lb_ready, lb_out, lb_busy, lb_cc;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_char_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_out        (tx_out),
        .busy          (busy),
        .char_complete (cc)
    );

    serial_char_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) u_lb (
        .clk           (clk),
        .reset_n       (reset_n),
        .tx_data       (lb_data),
        .tx_valid      (lb_valid),
        .tx_ready      (lb_ready),
        .tx_out        (lb_out),
        .busy          (lb_busy),
        .char_complete (lb_cc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line image of an 8-bit frame, bit 0 = start bit.
    function automatic logic [9:0] frame8(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic send8(input logic [7:0] d);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        if (!tx_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: tx_ready=%b required 1", tx_ready);
        end
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || cc !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_hold[%0d]: out/ready/busy/cc=%b%b%b%b required 1100",
                         i, tx_out, tx_ready, busy, cc);
            end
        end
        reset_n  = 1'b1;
        tx_valid = 1'b0;
        tick();
        compared++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: out/busy=%b%b required 10", tx_out, busy);
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] exp = 10'b1101001010;
        send8(8'hA5);
        compared++;
        if (busy !== 1'b1 || tx_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL accept_flags: busy/ready=%b%b required 10", busy, tx_ready);
        end
        for (int i = 0; i < 40; i++) begin
            compared++;
            if (tx_out !== exp[i/4] || cc !== 1'b0) begin
                mismatched++;
                $display("FAIL single_line[%0d]: out=%b cc=%b required out=%b cc=0",
                         i, tx_out, cc, exp[i/4]);
            end
            tick();
        end
        compared++;
        if (cc !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_out !== 1'b1) begin
            mismatched++;
            $display("FAIL single_complete: cc/ready/busy/out=%b%b%b%b required 1101",
                     cc, tx_ready, busy, tx_out);
        end
        tick();
        compared++;
        if (cc !== 1'b0) begin
            mismatched++;
            $display("FAIL single_pulse_width: cc=%b required 0", cc);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e0 = frame8(8'h00);
        logic [9:0] e1 = frame8(8'hFF);
        int pulses = 0;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            pulses += int'(cc);
            compared++;
            if (tx_out !== e0[i/4]) begin
                mismatched++;
                $display("FAIL b2b_first[%0d]: out=%b required %b", i, tx_out, e0[i/4]);
            end
            tick();
        end
        pulses += int'(cc);
        compared++;
        if (cc !== 1'b1 || tx_out !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_gap: cc/out=%b%b required 11", cc, tx_out);
        end
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pulses += int'(cc);
            compared++;
            if (tx_out !== e1[i/4]) begin
                mismatched++;
                $display("FAIL b2b_second[%0d]: out=%b required %b", i, tx_out, e1[i/4]);
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            pulses += int'(cc);
            tick();
        end
        compared++;
        if (pulses != 2) begin
            mismatched++;
            $display("FAIL b2b_pulses: count=%0d required 2", pulses);
        end
    endtask

    task automatic test_busy_ignore();
        logic [9:0] exp = frame8(8'h81);
        send8(8'h81);
        for (int i = 0; i < 40; i++) begin
            if (i == 12) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end
            if (i == 13) tx_valid = 1'b0;
            if (i == 20) tx_data = 8'hFF;
            compared++;
            if (tx_out !== exp[i/4]) begin
                mismatched++;
                $display("FAIL ignore_line[%0d]: out=%b required %b", i, tx_out, exp[i/4]);
            end
            tick();
        end
        compared++;
        if (cc !== 1'b1) begin
            mismatched++;
            $display("FAIL ignore_complete: cc=%b required 1", cc);
        end
        for (int i = 0; i < 48; i++) begin
            tick();
            compared++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL ignore_idle[%0d]: out/busy=%b%b required 10", i, tx_out, busy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] ef = frame8(8'hF0);
        logic [9:0] e5 = frame8(8'h5A);
        send8(8'hF0);
        for (int i = 0; i < 18; i++) begin
            compared++;
            if (tx_out !== ef[i/4]) begin
                mismatched++;
                $display("FAIL abort_line[%0d]: out=%b required %b", i, tx_out, ef[i/4]);
            end
            if (i < 17) tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        compared++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || cc !== 1'b0 || tx_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_reset: out/busy/cc/ready=%b%b%b%b required 1001",
                     tx_out, busy, cc, tx_ready);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            compared++;
            if (cc !== 1'b0 || tx_out !== 1'b1) begin
                mismatched++;
                $display("FAIL abort_quiet[%0d]: cc/out=%b%b required 01", i, cc, tx_out);
            end
        end
        send8(8'h5A);
        for (int i = 0; i < 40; i++) begin
            compared++;
            if (tx_out !== e5[i/4]) begin
                mismatched++;
                $display("FAIL abort_next[%0d]: out=%b required %b", i, tx_out, e5[i/4]);
            end
            tick();
        end
        compared++;
        if (cc !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_next_complete: cc=%b required 1", cc);
        end
        tick();
    endtask

    task automatic test_loopback(input logic [6:0] d);
        logic [6:0] rx = 7'h00;
        logic       prev;
        logic       en;
        lb_data  = d;
        lb_valid = 1'b1;
        prev     = lb_out;
        tick();
        lb_valid = 1'b0;
        en = prev && !lb_out;
        compared++;
        if (en !== 1'b1) begin
            mismatched++;
            $display("FAIL lb_enable: prev=%b now=%b required falling edge", prev, lb_out);
        end
        for (int k = 0; k <= 40; k++) begin
            if (k == 2) begin
                compared++;
                if (lb_out !== 1'b0) begin
                    mismatched++;
                    $display("FAIL lb_start_mid: out=%b required 0", lb_out);
                end
            end
            if (k >= 6 && k < 34 && (k % 4) == 2) rx[(k-6)/4] = lb_out;
            if (k == 34 || k == 38) begin
                compared++;
                if (lb_out !== 1'b1) begin
                    mismatched++;
                    $display("FAIL lb_stop@%0d: out=%b required 1", k, lb_out);
                end
            end
            if (k == 40) begin
                compared++;
                if (lb_cc !== 1'b1) begin
                    mismatched++;
                    $display("FAIL lb_complete: cc=%b required 1", lb_cc);
                end
            end else if (lb_cc !== 1'b0) begin
                compared++;
                mismatched++;
                $display("FAIL lb_early_complete@%0d: cc=%b required 0", k, lb_cc);
            end
            tick();
        end
        compared++;
        if (rx !== d) begin
            mismatched++;
            $display("FAIL lb_char: got=%h required %h", rx, d);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_loopback(7'h55);
        test_loopback(7'h2A);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
